// File: rtl/mux_pipe_nto1_pkg.sv
// Shared constants and helpers for the pipelined N-to-1 multiplexer.
package mux_pipe_nto1_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_NUM_IN = 32;
  localparam int unsigned DEF_LAT    = 2;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One elastic register stage: valid bit plus payload, with a ready chained from downstream.
module mux_pipe_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [PW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;

  assign o_ready = !r_valid || i_ready;

  // Payload is zeroed when the stage empties so an idle output reads as all-zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mux_pipe_nto1.sv
// N-to-1 multiplexer with explicit or round-robin select, followed by LAT elastic stages.
module mux_pipe_nto1
  import mux_pipe_nto1_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned NUM_IN = DEF_NUM_IN,
  parameter  int unsigned LAT    = DEF_LAT,
  localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    rr_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        q,
  output logic [SEL_W-1:0]        q_sel,
  output logic                    q_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned PW = WIDTH + SEL_W + 1;

  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_eff_sel;
  logic             w_err;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_ch    [NUM_IN];
  logic             w_valid [LAT+1];
  logic             w_ready [LAT+1];
  logic [PW-1:0]    w_pay   [LAT+1];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
    assign w_ch[k] = data[k*WIDTH +: WIDTH];
  end

  assign w_eff_sel = rr_mode ? r_rr_ptr : sel;
  assign w_err     = ({1'b0, w_eff_sel} >= (SEL_W+1)'(NUM_IN));

  // Out-of-range selects only exist for non-power-of-two NUM_IN; they yield zero data.
  always_comb begin
    w_sel_data = '0;
    if (!w_err) w_sel_data = w_ch[w_eff_sel];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (in_valid && w_ready[0] && rr_mode) begin
      r_rr_ptr <= (r_rr_ptr == SEL_W'(NUM_IN - 1)) ? '0 : r_rr_ptr + 1'b1;
    end
  end

  assign w_valid[0]   = in_valid;
  assign w_pay[0]     = {w_err, w_eff_sel, w_sel_data};
  assign w_ready[LAT] = out_ready;

  for (genvar i = 0; i < LAT; i++) begin : g_stage
    mux_pipe_stage #(
      .PW(PW)
    ) u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .i_valid(w_valid[i]),
      .o_ready(w_ready[i]),
      .i_data (w_pay[i]),
      .i_ready(w_ready[i+1]),
      .o_valid(w_valid[i+1]),
      .o_data (w_pay[i+1])
    );
  end

  assign in_ready            = w_ready[0];
  assign out_valid           = w_valid[LAT];
  assign {q_err, q_sel, q}   = w_pay[LAT];

endmodule
